// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, immediate generation,
// combinational branch/jump resolution and the ID/EXE pipeline registers.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_decode,
  input  logic [31:0] instr_decode,
  input  logic [31:0] mem_wb,
  input  logic [31:0] instr_wb,
  input  logic [2:0]  imm_sel,
  input  logic        reg_write_en,
  input  logic [2:0]  br_op,
  output logic [31:0] pc_exe,
  output logic [31:0] instr_exe,
  output logic [31:0] rs1_data_exe,
  output logic [31:0] rs2_data_exe,
  output logic [31:0] imm_exe,
  output logic [4:0]  rs1_addr_exe,
  output logic [4:0]  rs2_addr_exe,
  output logic [4:0]  rd_addr_exe,
  output logic [31:0] br_decode,
  output logic [31:0] jal_decode,
  output logic [31:0] jalr_decode,
  output logic        br_true
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RA_W     = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] BR_SEQ  = 3'b000;
  localparam logic [2:0] BR_SNE  = 3'b001;
  localparam logic [2:0] BR_SLT  = 3'b100;
  localparam logic [2:0] BR_SGE  = 3'b101;
  localparam logic [2:0] BR_SLTU = 3'b110;
  localparam logic [2:0] BR_SGEU = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
  } idex_t;

  logic [XLEN-1:0] r_regs [NUM_REGS];
  idex_t           r_idex;

  logic [RA_W-1:0] w_rs1_addr;
  logic [RA_W-1:0] w_rs2_addr;
  logic [RA_W-1:0] w_rd_addr;
  logic [RA_W-1:0] w_rd_wb;
  logic            w_wb_we;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_sel;
  logic [XLEN-1:0] w_jalr_sum;
  logic            w_br_true;
  idex_t           w_idex_next;
  logic            w_unused;

  assign w_rs1_addr = instr_decode[19:15];
  assign w_rs2_addr = instr_decode[24:20];
  assign w_rd_addr  = instr_decode[11:7];
  assign w_rd_wb    = instr_wb[11:7];

  // Writes to x0 are dropped here so the bypass and the array agree on x0.
  assign w_wb_we = reg_write_en && (w_rd_wb != '0);

  // Only the rd field of the WB instruction is needed.
  assign w_unused = ^{instr_wb[31:12], instr_wb[6:0]};

  // Register file; reset wins over a pending write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[w_rd_wb] <= mem_wb;
    end
  end

  // Read ports with same-cycle write-through bypass.
  always_comb begin
    w_rs1_data = r_regs[w_rs1_addr];
    w_rs2_data = r_regs[w_rs2_addr];
    if (w_rs1_addr == '0) begin
      w_rs1_data = '0;
    end else if (w_wb_we && (w_rd_wb == w_rs1_addr)) begin
      w_rs1_data = mem_wb;
    end
    if (w_rs2_addr == '0) begin
      w_rs2_data = '0;
    end else if (w_wb_we && (w_rd_wb == w_rs2_addr)) begin
      w_rs2_data = mem_wb;
    end
  end

  assign w_imm_i = {{20{instr_decode[31]}}, instr_decode[31:20]};
  assign w_imm_s = {{20{instr_decode[31]}}, instr_decode[31:25], instr_decode[11:7]};
  assign w_imm_b = {{19{instr_decode[31]}}, instr_decode[31], instr_decode[7],
                    instr_decode[30:25], instr_decode[11:8], 1'b0};
  assign w_imm_u = {instr_decode[31:12], 12'b0};
  assign w_imm_j = {{11{instr_decode[31]}}, instr_decode[31], instr_decode[19:12],
                    instr_decode[20], instr_decode[30:21], 1'b0};

  always_comb begin
    w_imm_sel = '0;
    case (imm_sel)
      IMM_I:   w_imm_sel = w_imm_i;
      IMM_S:   w_imm_sel = w_imm_s;
      IMM_B:   w_imm_sel = w_imm_b;
      IMM_U:   w_imm_sel = w_imm_u;
      IMM_J:   w_imm_sel = w_imm_j;
      default: w_imm_sel = '0;
    endcase
  end

  // Branch condition on bypassed operands.
  always_comb begin
    w_br_true = 1'b0;
    case (br_op)
      BR_SEQ:  w_br_true = (w_rs1_data == w_rs2_data);
      BR_SNE:  w_br_true = (w_rs1_data != w_rs2_data);
      BR_SLT:  w_br_true = ($signed(w_rs1_data) <  $signed(w_rs2_data));
      BR_SGE:  w_br_true = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      BR_SLTU: w_br_true = (w_rs1_data <  w_rs2_data);
      BR_SGEU: w_br_true = (w_rs1_data >= w_rs2_data);
      default: w_br_true = 1'b0;
    endcase
  end

  assign w_jalr_sum  = XLEN'(w_rs1_data + w_imm_i);
  assign br_decode   = XLEN'(pc_decode + w_imm_b);
  assign jal_decode  = XLEN'(pc_decode + w_imm_j);
  assign jalr_decode = {w_jalr_sum[XLEN-1:1], 1'b0};
  assign br_true     = w_br_true;

  always_comb begin
    w_idex_next          = '0;
    w_idex_next.pc       = pc_decode;
    w_idex_next.instr    = instr_decode;
    w_idex_next.rs1_data = w_rs1_data;
    w_idex_next.rs2_data = w_rs2_data;
    w_idex_next.imm      = w_imm_sel;
    w_idex_next.rs1_addr = w_rs1_addr;
    w_idex_next.rs2_addr = w_rs2_addr;
    w_idex_next.rd_addr  = w_rd_addr;
  end

  // ID/EXE pipeline registers; reset loads a NOP bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex       <= '0;
      r_idex.instr <= NOP_INSTR;
    end else begin
      r_idex <= w_idex_next;
    end
  end

  assign pc_exe       = r_idex.pc;
  assign instr_exe    = r_idex.instr;
  assign rs1_data_exe = r_idex.rs1_data;
  assign rs2_data_exe = r_idex.rs2_data;
  assign imm_exe      = r_idex.imm;
  assign rs1_addr_exe = r_idex.rs1_addr;
  assign rs2_addr_exe = r_idex.rs2_addr;
  assign rd_addr_exe  = r_idex.rd_addr;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus queues expected values tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_decode;
  logic [31:0] instr_decode;
  logic [31:0] mem_wb;
  logic [31:0] instr_wb;
  logic [2:0]  imm_sel;
  logic        reg_write_en;
  logic [2:0]  br_op;
  logic [31:0] pc_exe, instr_exe, rs1_data_exe, rs2_data_exe, imm_exe;
  logic [4:0]  rs1_addr_exe, rs2_addr_exe, rd_addr_exe;
  logic [31:0] br_decode, jal_decode, jalr_decode;
  logic        br_true;

  decode_stage dut (
    .clk(clk), .rst(rst), .pc_decode(pc_decode), .instr_decode(instr_decode),
    .mem_wb(mem_wb), .instr_wb(instr_wb), .imm_sel(imm_sel),
    .reg_write_en(reg_write_en), .br_op(br_op),
    .pc_exe(pc_exe), .instr_exe(instr_exe), .rs1_data_exe(rs1_data_exe),
    .rs2_data_exe(rs2_data_exe), .imm_exe(imm_exe), .rs1_addr_exe(rs1_addr_exe),
    .rs2_addr_exe(rs2_addr_exe), .rd_addr_exe(rd_addr_exe), .br_decode(br_decode),
    .jal_decode(jal_decode), .jalr_decode(jalr_decode), .br_true(br_true)
  );

  typedef enum int {
    S_BR_TRUE, S_BR, S_JAL, S_JALR, S_PC_EXE, S_INSTR_EXE, S_RS1_EXE,
    S_RS2_EXE, S_IMM_EXE, S_RS1A_EXE, S_RS2A_EXE, S_RDA_EXE
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    int          cyc;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_BR_TRUE:   return {31'b0, br_true};
      S_BR:        return br_decode;
      S_JAL:       return jal_decode;
      S_JALR:      return jalr_decode;
      S_PC_EXE:    return pc_exe;
      S_INSTR_EXE: return instr_exe;
      S_RS1_EXE:   return rs1_data_exe;
      S_RS2_EXE:   return rs2_data_exe;
      S_IMM_EXE:   return imm_exe;
      S_RS1A_EXE:  return {27'b0, rs1_addr_exe};
      S_RS2A_EXE:  return {27'b0, rs2_addr_exe};
      S_RDA_EXE:   return {27'b0, rd_addr_exe};
      default:     return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every entry due this cycle; overdue entries count as misses.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        act = sample(sb[i].sig);
        n_vec++;
        if (act !== sb[i].exp) begin
          n_err++;
          $display("FAIL %s cyc=%0d actual=0x%08h expected=0x%08h",
                   sb[i].sig.name(), cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s never sampled (due cyc=%0d)", sb[i].sig.name(), sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic exp_c(input sig_e s, input logic [31:0] v);
    chk_t c;
    c.sig = s; c.exp = v; c.cyc = cyc;
    sb.push_back(c);
  endtask

  task automatic exp_r(input sig_e s, input logic [31:0] v);
    chk_t c;
    c.sig = s; c.exp = v; c.cyc = cyc + 1;
    sb.push_back(c);
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    reg_write_en = we;
    instr_wb     = {20'b0, rd, 7'b0110011};
    mem_wb       = d;
  endtask

  localparam logic [2:0] SEQ = 3'b000, SNE = 3'b001, SLT = 3'b100,
                         SGE = 3'b101, SLTU = 3'b110, SGEU = 3'b111;

  initial begin
    rst = 1'b1; pc_decode = '0; instr_decode = 32'h0002_8013;
    imm_sel = 3'b000; br_op = SEQ;
    set_wb(1'b0, 5'd0, 32'h0);

    // Reset state of the ID/EXE registers.
    tick();
    exp_r(S_INSTR_EXE, 32'h0000_0013);
    exp_r(S_RS1_EXE, 32'h0);
    exp_r(S_PC_EXE, 32'h0);
    exp_r(S_IMM_EXE, 32'h0);
    exp_r(S_RS1A_EXE, 32'h0);

    // rs1=x5, rs2=x0 after reset: both read zero.
    tick();
    rst = 1'b0;
    exp_c(S_BR_TRUE, 32'h1);
    exp_r(S_RS1A_EXE, 32'd5);
    exp_r(S_RS1_EXE, 32'h0);
    exp_r(S_INSTR_EXE, 32'h0002_8013);

    // Write x1 with bypass visible before the edge.
    tick();
    instr_decode = 32'h0000_8013;
    set_wb(1'b1, 5'd1, 32'hFFFF_FFFF);
    exp_c(S_BR_TRUE, 32'h0);
    exp_c(S_JALR, 32'hFFFF_FFFE);
    exp_r(S_RS1_EXE, 32'hFFFF_FFFF);

    // x1 persists; sweep compare ops with rs1=x1, rs2=x0.
    tick();
    set_wb(1'b0, 5'd1, 32'h0);
    br_op = SEQ;  exp_c(S_BR_TRUE, 32'h0);
    exp_r(S_RS1_EXE, 32'hFFFF_FFFF);
    tick(); br_op = SNE;    exp_c(S_BR_TRUE, 32'h1);
    tick(); br_op = SLT;    exp_c(S_BR_TRUE, 32'h1);
    tick(); br_op = SLTU;   exp_c(S_BR_TRUE, 32'h0);
    tick(); br_op = SGE;    exp_c(S_BR_TRUE, 32'h0);
    tick(); br_op = SGEU;   exp_c(S_BR_TRUE, 32'h1);
    tick(); br_op = 3'b010; exp_c(S_BR_TRUE, 32'h0);

    // Writing x0 has no effect.
    tick();
    instr_decode = 32'h0000_0013; br_op = SEQ;
    set_wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    exp_c(S_BR_TRUE, 32'h1);
    exp_c(S_JALR, 32'h0);
    exp_r(S_RS1_EXE, 32'h0);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    exp_c(S_BR_TRUE, 32'h1);

    // Branch and JAL targets plus B/J immediates.
    tick();
    pc_decode = 32'h100; instr_decode = 32'hFE00_0EE3; imm_sel = 3'b010;
    exp_c(S_BR, 32'h0000_00FC);
    exp_r(S_IMM_EXE, 32'hFFFF_FFFC);
    exp_r(S_PC_EXE, 32'h100);
    tick();
    instr_decode = 32'h0080_006F; imm_sel = 3'b100;
    exp_c(S_JAL, 32'h0000_0108);
    exp_r(S_IMM_EXE, 32'h8);
    exp_r(S_RDA_EXE, 32'h0);

    // Write x2 while rs2 reads it through the bypass.
    tick();
    pc_decode = 32'h0; instr_decode = 32'h0020_0013; br_op = SLTU;
    set_wb(1'b1, 5'd2, 32'h0000_1001);
    exp_c(S_BR_TRUE, 32'h1);
    exp_r(S_RS2_EXE, 32'h0000_1001);

    // JALR target and I immediate, rs1=x2, rs2=x3.
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    instr_decode = 32'h0031_0067; imm_sel = 3'b000; br_op = SLT;
    exp_c(S_JALR, 32'h0000_1004);
    exp_c(S_BR_TRUE, 32'h0);
    exp_r(S_IMM_EXE, 32'h3);
    exp_r(S_RS1_EXE, 32'h0000_1001);
    exp_r(S_RS2_EXE, 32'h0);
    exp_r(S_RS1A_EXE, 32'd2);
    exp_r(S_RS2A_EXE, 32'd3);
    tick(); br_op = SGE; exp_c(S_BR_TRUE, 32'h1);

    // U, S and unused immediate selects.
    tick();
    instr_decode = 32'h8000_0037; imm_sel = 3'b011;
    exp_r(S_IMM_EXE, 32'h8000_0000);
    tick();
    instr_decode = 32'hFE00_0FA3; imm_sel = 3'b001;
    exp_r(S_IMM_EXE, 32'hFFFF_FFFF);
    tick();
    imm_sel = 3'b101;
    exp_r(S_IMM_EXE, 32'h0);

    // Reset mid-operation discards the pending write of x3 and the ID/EXE contents.
    tick();
    rst = 1'b1; pc_decode = 32'h200; instr_decode = 32'h0031_0067; imm_sel = 3'b000;
    set_wb(1'b1, 5'd3, 32'h0000_0055);
    exp_r(S_PC_EXE, 32'h0);
    exp_r(S_INSTR_EXE, 32'h0000_0013);
    exp_r(S_RS1_EXE, 32'h0);
    exp_r(S_IMM_EXE, 32'h0);
    exp_r(S_RS2A_EXE, 32'h0);
    tick();
    rst = 1'b0; br_op = SEQ;
    set_wb(1'b0, 5'd0, 32'h0);
    exp_c(S_JALR, 32'h0000_0002);
    exp_c(S_BR_TRUE, 32'h1);
    exp_r(S_RS1_EXE, 32'h0);
    exp_r(S_RS2_EXE, 32'h0);

    tick();
    tick();
    tick();
    if (sb.size() != 0) begin
      n_vec += sb.size();
      n_err += sb.size();
      $display("FAIL scoreboard %0d entries left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
